// File: rtl/xbar_nor_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | xbar_nor_scheduler: arbitrates two requesters, loads 16 cells, then runs |
// | a ROM program on a NOR crossbar. Optional XBAR_SCHED_PERF_EN: perf ctrs. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module xbar_nor_scheduler #(
  parameter int PROG_DEPTH = 128,
  parameter int MAX_RD     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid_i,
  output logic [1:0]        req_ready_o,
  input  logic [31:0]       req_vec_i,
  output logic [6:0]        prog_addr_o,
  input  logic [22:0]       prog_data_i,
  output logic              xb_valid_o,
  input  logic              xb_ready_i,
  output logic [1:0]        xb_op_o,
  output logic [6:0]        xb_dst_o,
  output logic [6:0]        xb_a_o,
  output logic [6:0]        xb_b_o,
  output logic              xb_wdata_o,
  input  logic              xb_rvalid_i,
  input  logic              xb_rdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic              resp_id_o,
  output logic [MAX_RD-1:0] resp_data_o,
  output logic              resp_err_o
`ifdef XBAR_SCHED_PERF_EN
  ,
  output logic [15:0]       perf_jobs_o,
  output logic [15:0]       perf_stall_o
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    FETCH   = 3'd2,
    ISSUE   = 3'd3,
    WAIT_RD = 3'd4,
    RESP    = 3'd5
  } state_t;

  localparam logic [1:0] OP_INV1   = 2'b01;
  localparam logic [1:0] OP_READ   = 2'b10;
  localparam logic [1:0] OP_WRITE  = 2'b11;
  localparam int         KW        = $clog2(MAX_RD + 1);
  localparam logic [6:0] LAST_ADDR = 7'(PROG_DEPTH - 1);

  state_t            state_q, state_d;
  logic              rr_q, rr_d;
  logic              id_q, id_d;
  logic [15:0]       vec_q, vec_d;
  logic [3:0]        cell_q, cell_d;
  logic [6:0]        addr_q, addr_d;
  logic [KW-1:0]     rdcnt_q, rdcnt_d;
  logic [1:0]        req_ready_q, req_ready_d;
  logic              xb_valid_q, xb_valid_d;
  logic [1:0]        op_q, op_d;
  logic [6:0]        dst_q, dst_d, a_q, a_d, b_q, b_d;
  logic              wdata_q, wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [MAX_RD-1:0] resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;

  logic              grant;
  logic [15:0]       vec_sel;
  logic [3:0]        cell_nxt;
  logic              advance;

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    id_d         = id_q;
    vec_d        = vec_q;
    cell_d       = cell_q;
    addr_d       = addr_q;
    rdcnt_d      = rdcnt_q;
    req_ready_d  = 2'b00;
    xb_valid_d   = xb_valid_q;
    op_d         = op_q;
    dst_d        = dst_q;
    a_d          = a_q;
    b_d          = b_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    advance      = 1'b0;
    // Contention goes to the pointer; a lone requester wins outright.
    grant        = (req_valid_i == 2'b11) ? rr_q : ~req_valid_i[0];
    vec_sel      = grant ? req_vec_i[31:16] : req_vec_i[15:0];
    cell_nxt     = cell_q + 4'd1;

    case (state_q)
      IDLE: begin
        if (|req_valid_i) begin
          req_ready_d = grant ? 2'b10 : 2'b01;
          rr_d        = ~grant;
          id_d        = grant;
          vec_d       = vec_sel;
          cell_d      = 4'd0;
          rdcnt_d     = '0;
          resp_data_d = '0;
          resp_err_d  = 1'b0;
          xb_valid_d  = 1'b1;
          op_d        = OP_WRITE;
          dst_d       = 7'd0;
          a_d         = 7'd0;
          b_d         = 7'd0;
          wdata_d     = vec_sel[0];
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (xb_valid_q && xb_ready_i) begin
          if (cell_q == 4'd15) begin
            xb_valid_d = 1'b0;
            addr_d     = 7'd0;
            state_d    = FETCH;
          end else begin
            cell_d  = cell_nxt;
            dst_d   = {3'b000, cell_nxt};
            wdata_d = vec_q[cell_nxt];
          end
        end
      end
      FETCH: state_d = ISSUE;
      ISSUE: begin
        // First ISSUE cycle decodes the ROM word; later cycles hold the command.
        if (!xb_valid_q) begin
          if (prog_data_i[22:21] == OP_WRITE) begin
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else if (prog_data_i[22:21] == OP_READ && rdcnt_q == KW'(MAX_RD)) begin
            resp_err_d   = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else begin
            xb_valid_d = 1'b1;
            op_d       = prog_data_i[22:21];
            dst_d      = prog_data_i[20:14];
            a_d        = prog_data_i[13:7];
            b_d        = (prog_data_i[22:21] == OP_INV1) ? 7'd0 : prog_data_i[6:0];
          end
        end else if (xb_ready_i) begin
          xb_valid_d = 1'b0;
          if (op_q == OP_READ) state_d = WAIT_RD;
          else                 advance = 1'b1;
        end
      end
      WAIT_RD: begin
        if (xb_rvalid_i) begin
          resp_data_d[rdcnt_q] = xb_rdata_i;
          rdcnt_d              = rdcnt_q + KW'(1);
          advance              = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Running off the end of the ROM without END is a program error.
    if (advance) begin
      if (addr_q == LAST_ADDR) begin
        resp_err_d   = 1'b1;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end else begin
        addr_d  = addr_q + 7'd1;
        state_d = FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_q         <= 1'b0;
      id_q         <= 1'b0;
      vec_q        <= 16'd0;
      cell_q       <= 4'd0;
      addr_q       <= 7'd0;
      rdcnt_q      <= '0;
      req_ready_q  <= 2'b00;
      xb_valid_q   <= 1'b0;
      op_q         <= 2'b00;
      dst_q        <= 7'd0;
      a_q          <= 7'd0;
      b_q          <= 7'd0;
      wdata_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      id_q         <= id_d;
      vec_q        <= vec_d;
      cell_q       <= cell_d;
      addr_q       <= addr_d;
      rdcnt_q      <= rdcnt_d;
      req_ready_q  <= req_ready_d;
      xb_valid_q   <= xb_valid_d;
      op_q         <= op_d;
      dst_q        <= dst_d;
      a_q          <= a_d;
      b_q          <= b_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign prog_addr_o  = addr_q;
  assign xb_valid_o   = xb_valid_q;
  assign xb_op_o      = op_q;
  assign xb_dst_o     = dst_q;
  assign xb_a_o       = a_q;
  assign xb_b_o       = b_q;
  assign xb_wdata_o   = wdata_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_id_o    = id_q;
  assign resp_data_o  = resp_data_q;
  assign resp_err_o   = resp_err_q;

`ifdef XBAR_SCHED_PERF_EN
  logic [15:0] perf_jobs_q, perf_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_jobs_q  <= 16'd0;
      perf_stall_q <= 16'd0;
    end else begin
      if (resp_valid_q && resp_ready_i && perf_jobs_q != 16'hFFFF)
        perf_jobs_q <= perf_jobs_q + 16'd1;
      if (xb_valid_q && !xb_ready_i && perf_stall_q != 16'hFFFF)
        perf_stall_q <= perf_stall_q + 16'd1;
    end
  end

  assign perf_jobs_o  = perf_jobs_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: doc/xbar_nor_scheduler.md
XBAR_NOR_SCHEDULER -- requirements
Module: xbar_nor_scheduler

Interface
REQ-001 SHALL have parameter PROG_DEPTH, default 128: program-memory entries, addressed by prog_addr.
REQ-002 SHALL have parameter MAX_RD, default 5: maximum READ results per job (width of resp_data).
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have ports req_valid / req_ready  input / output  2 each: per-requester job handshake.
REQ-006 SHALL have port req_vec  input  32: requester r's 16-bit input vector on bits [16r+15:16r], with bit 0 mapping to cell 0.
REQ-007 SHALL have ports prog_addr  output  7 and prog_data  input  23: synchronous program ROM with 1-cycle read latency; prog_data = {op[22:21], dst[20:14], a[13:7], b[6:0]}.
REQ-008 SHALL have ports xb_valid / xb_ready  output / input  1 each: crossbar command handshake.
REQ-009 SHALL have ports xb_op  output  2 (00 NOR2, 01 INV1, 10 READ, 11 WRITE); xb_dst, xb_a, xb_b  output  7 each; xb_wdata  output  1.
REQ-010 SHALL have ports xb_rvalid / xb_rdata  input  1 each: READ result, arriving one or more cycles after the READ command is accepted.
REQ-011 SHALL have ports resp_valid  output  1, resp_ready  input  1, resp_id  output  1, resp_data  output  MAX_RD, resp_err  output  1.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, FETCH, ISSUE, WAIT_RD, RESP.
REQ-013 In IDLE with any req_valid, SHALL grant one requester, pulse its req_ready for 1 cycle, latch req_vec slice and id, and enter LOAD.
REQ-014 Arbitration SHALL be round-robin: if both requesters are valid, grant the one not granted last; the pointer favours requester 0 after reset.
REQ-015 LOAD SHALL issue 16 WRITE commands, cells 0..15 in order, with xb_wdata = latched bit; it advances only on xb_valid&&xb_ready.
REQ-016 After the 16th WRITE is accepted, SHALL set prog_addr=0 and enter FETCH; FETCH lasts exactly 1 cycle (ROM latency), then ISSUE.
REQ-017 In ISSUE with op NOR2/INV1/READ, SHALL drive xb_op/dst/a/b from prog_data (registered) with xb_valid=1 until accepted; INV1 ignores b.
REQ-018 On accepting NOR2/INV1, SHALL increment prog_addr and go to FETCH.
REQ-019 On accepting READ, SHALL go to WAIT_RD; on xb_rvalid, SHALL store xb_rdata into resp_data[k] (k = READ count, first READ in bit 0), increment prog_addr, and go to FETCH.
REQ-020 In ISSUE, op 11 (END) SHALL enter RESP with resp_err=0; no crossbar command is issued.
REQ-021 SHALL enter RESP with resp_err=1 if prog_addr would wrap past PROG_DEPTH-1 without END, or on a READ when k==MAX_RD; that READ is not issued.
REQ-022 RESP SHALL hold resp_valid, resp_id, resp_data, resp_err stable until resp_ready, then go to IDLE; unread resp_data bits SHALL be 0.
REQ-023 xb_valid SHALL never drop before acceptance, and command fields SHALL stay stable while xb_valid&&!xb_ready.
REQ-024 Requests arriving outside IDLE SHALL be held off (req_ready=0); a request valid in the same cycle RESP completes SHALL be granted no earlier than the next IDLE cycle.

Reset
REQ-025 When rst_n is low, SHALL be in IDLE with req_ready=0, xb_valid=0, xb_op/dst/a/b/wdata=0, prog_addr=0, resp_valid=0, resp_data=0, resp_err=0, resp_id=0, and the RR pointer favouring requester 0.
REQ-026 Reset asserted mid-job SHALL abandon the job immediately with no response.

Configuration
REQ-027 With macro XBAR_SCHED_PERF_EN defined, SHALL add outputs perf_jobs (16b, count of RESP handshakes) and perf_stall (16b, cycles with xb_valid&&!xb_ready); both saturate and reset to 0. Without the macro, these ports and their logic SHALL be absent.

Verification
REQ-028 Requester 0 sends req_vec[15:0]=16'hA5F0 with a program of INV1(16,0), READ(16), END and xb_ready always 1 -> 16 WRITEs with wdata matching 0xA5F0 LSB-first, then resp_data=5'b00001 (sent as read back by the crossbar model), resp_err=0, resp_id=0.
REQ-029 req_valid=2'b11 held for three jobs -> grant order 0,1,0; resp_id sequence 0,1,0.
REQ-030 xb_ready low for 3 cycles during one NOR2 -> command fields held constant for those cycles; with the macro defined, perf_stall increments by 3.
REQ-031 Program with 6 READs before END -> resp_err=1 and only 5 READ commands issued; a program with no END in 128 entries -> resp_err=1.
REQ-032 rst_n pulled low during WAIT_RD -> all outputs at reset values asynchronously; no resp_valid after release until a new request.
REQ-033 resp_ready held low for 10 cycles -> resp_valid and resp_data stable; the other requester's req_ready stays 0 until 1 cycle after acceptance.
